// File: rtl/tour_pkg.sv
// Shared constants for the knight's tour sequencer: FSM state codes, headings, opcodes, responses.
// Optional feature macro: TOUR_FANFARE_EN (horizontal legs use the fanfare opcode).
package tour_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t VERT  = 3'd1;
  localparam state_t HOLDV = 3'd2;
  localparam state_t HORZ  = 3'd3;
  localparam state_t HOLDH = 3'd4;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OPC_MOVE    = 4'h2;
  localparam logic [3:0] OPC_MOVE_FF = 4'h3;

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] OPC_HORZ = OPC_MOVE_FF;
`else
  localparam logic [3:0] OPC_HORZ = OPC_MOVE;
`endif

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;

  function automatic logic [15:0] pack_cmd(input logic [3:0] opc,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {opc, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_sequencer_if.sv
// Command-path bundle around the tour sequencer: UART side, solver side, command processor side.
interface tour_sequencer_if #(
  parameter int IDX_W = 5
);
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic [7:0]       resp;
  logic             tour_go;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;

  // master is the sequencer itself; slave is everything around it
  modport master (
    input  cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, resp, mv_indx, cmd, cmd_rdy
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, resp, mv_indx, cmd, cmd_rdy
  );
endinterface

// File: rtl/tour_move_decode.sv
// Combinational decode of a one-hot knight move into vertical and horizontal legs.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vhdg,
  output logic [3:0] vsq,
  output logic [7:0] hhdg,
  output logic [3:0] hsq
);

  // Priority chain: lowest set bit wins; an all-zero move yields N/0 on both legs
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    vhdg = HDG_N;
    vsq  = 4'd0;
    hhdg = HDG_N;
    hsq  = 4'd0;
    if (move[0]) begin
      vsq = 4'd2; hhdg = HDG_W; hsq = 4'd1;
    end else if (move[1]) begin
      vsq = 4'd2; hhdg = HDG_E; hsq = 4'd1;
    end else if (move[2]) begin
      vsq = 4'd1; hhdg = HDG_W; hsq = 4'd2;
    end else if (move[3]) begin
      vhdg = HDG_S; vsq = 4'd1; hhdg = HDG_W; hsq = 4'd2;
    end else if (move[4]) begin
      vhdg = HDG_S; vsq = 4'd2; hhdg = HDG_W; hsq = 4'd1;
    end else if (move[5]) begin
      vhdg = HDG_S; vsq = 4'd2; hhdg = HDG_E; hsq = 4'd1;
    end else if (move[6]) begin
      vhdg = HDG_S; vsq = 4'd1; hhdg = HDG_E; hsq = 4'd2;
    end else if (move[7]) begin
      vsq = 4'd1; hhdg = HDG_E; hsq = 4'd2;
    end
  end

endmodule

// File: rtl/tour_sequencer.sv
// Arbitrates the command interface between UART pass-through and knight's tour replay.
// Build option: TOUR_FANFARE_EN selects the fanfare opcode for horizontal legs (see tour_pkg).
module tour_sequencer
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  tour_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] mv_indx, mv_indx_nxt;
  logic [7:0]       vhdg, hhdg;
  logic [3:0]       vsq, hsq;
  logic [15:0]      vert_cmd, horz_cmd;
  logic             at_last;

  tour_move_decode u_decode (
    .move (bus.move),
    .vhdg (vhdg),
    .vsq  (vsq),
    .hhdg (hhdg),
    .hsq  (hsq)
  );

  assign vert_cmd    = pack_cmd(OPC_MOVE, vhdg, vsq);
  assign horz_cmd    = pack_cmd(OPC_HORZ, hhdg, hsq);
  assign at_last     = (mv_indx == LAST_IDX);
  assign bus.mv_indx = mv_indx;

  always_comb begin
    state_nxt   = state;
    mv_indx_nxt = mv_indx;
    case (state)
      IDLE: if (bus.tour_go) begin
        state_nxt   = VERT;
        mv_indx_nxt = '0;
      end
      VERT:  if (bus.clr_cmd_rdy) state_nxt = HOLDV;
      HOLDV: if (bus.send_resp)   state_nxt = HORZ;
      HORZ:  if (bus.clr_cmd_rdy) state_nxt = HOLDH;
      HOLDH: if (bus.send_resp) begin
        if (at_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = VERT;
          mv_indx_nxt = mv_indx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  // During a tour the UART side is fenced off; its command waits until IDLE
  always_comb begin
    bus.cmd              = vert_cmd;
    bus.cmd_rdy          = 1'b0;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = RESP_POS;
    case (state)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = RESP_DONE;
      end
      VERT:  bus.cmd_rdy = 1'b1;
      HOLDV: bus.cmd     = vert_cmd;
      HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b1;
      end
      HOLDH: begin
        bus.cmd = horz_cmd;
        if (bus.send_resp && at_last) bus.resp = RESP_DONE;
      end
      default: ;
    endcase
  end

endmodule
